// File: rtl/pedestrian_pkg.sv
// pedestrian_pkg: shared state encoding, default phase lengths and counter width
package pedestrian_pkg;
   typedef enum logic [1:0] {PARE, ANDA, PISCA} estado_t;
   localparam int WALK_TICKS_DEF  = 8;
   localparam int FLASH_TICKS_DEF = 4;
   localparam int CNT_W           = 4;
endpackage

// File: rtl/sincronizador_borda.sv
// sincronizador_borda: 2-flop synchronizer with rising-edge pulse
// ports: clk, reset (sync, active-high), d (async input), borda (one-cycle pulse on synchronized rise)
module sincronizador_borda (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic borda
);
   // s[1:0] synchronize d, s[2] holds the previous synchronized value
   logic [2:0] s;
   always_ff @(posedge clk)
      s <= reset ? 3'b000 : {s[1:0], d};
   assign borda = s[1] & ~s[2];
endmodule

// File: rtl/pedestrian_signal.sv
// pedestrian_signal: pedestrian walk/flash/don't-walk controller slaved to the vehicle red light
// ports: clk, reset (sync, active-high), verde/amarelo/vermelho (vehicle lights), botao (async button),
//        tick (time base), anda/pare (lamps), contagem (ticks left), pedido (request), falha (bad lights)
module pedestrian_signal import pedestrian_pkg::*; #(
   parameter int WALK_TICKS  = WALK_TICKS_DEF,
   parameter int FLASH_TICKS = FLASH_TICKS_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             verde,
   input  logic             amarelo,
   input  logic             vermelho,
   input  logic             botao,
   input  logic             tick,
   output logic             anda,
   output logic             pare,
   output logic [CNT_W-1:0] contagem,
   output logic             pedido,
   output logic             falha
);
   estado_t estado;
   logic    borda, verm_ant, inicia;
   sincronizador_borda u_sinc (.clk(clk), .reset(reset), .d(botao), .borda(borda));
   // odd parity excluding the all-ones case is exactly one-hot
   assign falha  = ~((verde ^ amarelo ^ vermelho) & ~(verde & amarelo & vermelho));
   // a request arriving on the very cycle red rises is served by that rise
   assign inicia = (estado == PARE) && !falha && (pedido || borda) && vermelho && !verm_ant;
   always_ff @(posedge clk) begin
      if (reset) begin
         estado   <= PARE;
         anda     <= 1'b0;
         pare     <= 1'b1;
         contagem <= '0;
         pedido   <= 1'b0;
         verm_ant <= 1'b0;
      end else begin
         verm_ant <= vermelho;
         if (inicia)
            pedido <= 1'b0;
         else if (borda && estado != ANDA)
            pedido <= 1'b1;
         if (estado != PARE && (falha || !vermelho)) begin
            estado   <= PARE;
            anda     <= 1'b0;
            pare     <= 1'b1;
            contagem <= '0;
         end else if (inicia) begin
            estado   <= ANDA;
            anda     <= 1'b1;
            pare     <= 1'b0;
            contagem <= CNT_W'(WALK_TICKS);
         end else if (tick && estado != PARE) begin
            if (contagem > 4'd1) begin
               contagem <= contagem - 4'd1;
               if (estado == PISCA)
                  pare <= ~pare;
            end else if (estado == ANDA) begin
               estado   <= PISCA;
               anda     <= 1'b0;
               pare     <= 1'b1;
               contagem <= CNT_W'(FLASH_TICKS);
            end else begin
               estado   <= PARE;
               pare     <= 1'b1;
               contagem <= '0;
            end
         end
      end
   end
endmodule

// File: doc/pedestrian_signal.md
PEDESTRIAN_SIGNAL -- requirements
Module: pedestrian_signal

Interface
REQ-001 Parameter WALK_TICKS, default 8: number of tick pulses the walk phase lasts (range 1..15).
REQ-002 Parameter FLASH_TICKS, default 4: number of tick pulses the flashing don't-walk phase lasts (range 1..15).
REQ-003 Port clk, input, 1: clock; all state SHALL update on its rising edge only.
REQ-004 Port reset, input, 1: reset, synchronous, active-high; clock clk.
REQ-005 Port verde, amarelo, vermelho, inputs, 1 each: registered vehicle light outputs from the upstream traffic-light controller; expected one-hot.
REQ-006 Port botao, input, 1: pedestrian push button, asynchronous to clk, level-high while pressed.
REQ-007 Port tick, input, 1: one-cycle time-base enable pulse.
REQ-008 Port anda, output, 1: walk lamp.
REQ-009 Port pare, output, 1: don't-walk lamp.
REQ-010 Port contagem, output, 4: remaining ticks in the current walk/flash phase.
REQ-011 Port pedido, output, 1: pedestrian request pending.
REQ-012 Port falha, output, 1: invalid vehicle-light encoding detected this cycle.

Function
REQ-013 botao SHALL pass through a 2-flop synchronizer; a request SHALL be latched on the rising edge of the synchronized signal (3-cycle latency from botao to pedido).
REQ-014 FSM states SHALL be PARE, ANDA and PISCA; reset state PARE.
REQ-015 PARE -> ANDA SHALL occur when pedido=1 and vermelho rises (vermelho=1, previous-cycle vermelho=0); contagem loads WALK_TICKS and pedido clears in the same transition.
REQ-016 A request latched in the same cycle as the vermelho rising edge SHALL be served by that edge.
REQ-017 In ANDA/PISCA, each tick with contagem>1 SHALL decrement contagem by 1; no change on non-tick cycles.
REQ-018 ANDA with tick and contagem=1 SHALL go to PISCA, loading FLASH_TICKS.
REQ-019 PISCA with tick and contagem=1 SHALL go to PARE, with contagem=0.
REQ-020 Outputs: PARE -> anda=0, pare=1, contagem=0; ANDA -> anda=1, pare=0; PISCA -> anda=0, pare toggles on every tick, starting at 1 on entry.
REQ-021 If vermelho=0 while in ANDA or PISCA, the FSM SHALL go to PARE on the next edge (abort), with contagem=0; pedido is unchanged.
REQ-022 Button edges during ANDA SHALL be ignored; edges during PISCA or PARE SHALL set pedido.
REQ-023 falha SHALL be 1 in any cycle where {verde,amarelo,vermelho} is not one-hot.
REQ-024 While falha=1, the FSM SHALL go to or hold PARE and SHALL NOT start ANDA.
REQ-025 When tick coincides with an abort or fault, the abort/fault SHALL take priority.

Reset
REQ-026 On reset the block SHALL set: state PARE, anda=0, pare=1, contagem=0, pedido=0, synchronizer flops 0, previous-vermelho register 0.
REQ-027 falha SHALL remain combinational from the inputs during reset.
REQ-028 Reset asserted mid-ANDA or mid-PISCA SHALL discard the pending request and remaining count.

Structure
REQ-029 A shared package pedestrian_pkg SHALL hold the state enum (PARE, ANDA, PISCA), the default WALK_TICKS/FLASH_TICKS constants and the counter width (4).
REQ-030 The synchronizer plus rising-edge detector SHALL be a sub-module named sincronizador_borda, instantiated once for botao.

Verification
REQ-031 Reset, then press botao for 5 cycles, then raise vermelho -> pedido=1 after 3 cycles; ANDA on the edge after vermelho rises, contagem=8; anda held for exactly 8 ticks; pare toggles over 4 ticks; return to PARE with contagem=0.
REQ-032 Raise vermelho with no request -> stay in PARE, anda never 1.
REQ-033 In ANDA with contagem=5, drop vermelho and raise verde -> PARE next cycle, contagem=0, falha=0.
REQ-034 Drive verde=1 and vermelho=1 together -> falha=1 that cycle and PARE held; with pedido=1, no ANDA starts until a valid vermelho rising edge.
REQ-035 Press botao during ANDA -> pedido stays 0; press during PISCA -> pedido=1 and served at the next vermelho edge.
REQ-036 Assert reset in PISCA with pedido=1 -> next cycle pare=1, anda=0, contagem=0, pedido=0.
